// File: rtl/kof_sprite_fetch.sv
// Sprite ROM address generator with a triggered animation player (IDLE/PLAY/DONE).
// Optional macro KOF_SPRITE_RETRIGGER_EN lets a trigger during PLAY restart the animation.
module kof_sprite_fetch #(
    parameter int FRAME_W    = 64,
    parameter int FRAME_H    = 96,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 6
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        trigger,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        flip,
    output logic [14:0] rom_address,
    output logic        sprite_on,
    output logic        busy,
    output logic [1:0]  frame_idx,
    output logic        done
);

`ifdef KOF_SPRITE_RETRIGGER_EN
    localparam logic RETRIGGER = 1'b1;
`else
    localparam logic RETRIGGER = 1'b0;
`endif

    localparam logic [5:0]  HOLD_LAST  = 6'(FRAME_HOLD - 1);
    localparam logic [1:0]  FRAME_LAST = 2'(NUM_FRAMES - 1);
    localparam logic [14:0] FRAME_SIZE = 15'(FRAME_W * FRAME_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]  frame_idx_q, frame_idx_d;
    logic [14:0] rom_address_q, rom_address_d;
    logic        sprite_on_q, sprite_on_d;

    logic [10:0] x_end_s, y_end_s;
    logic        inside_s;
    logic [9:0]  lx_s, ly_s, col_s;
    logic [14:0] addr_sum_s;

    // Animation sequencer: next state, hold counter and frame index
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        frame_idx_d = frame_idx_q;
        case (state_q)
            IDLE: begin
                frame_idx_d = 2'd0;
                hold_cnt_d  = 6'd0;
                if (trigger) begin
                    state_d = PLAY;
                end else begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                if (RETRIGGER && trigger) begin
                    frame_idx_d = 2'd0;
                    hold_cnt_d  = 6'd0;
                end else if (frame_start) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = 6'd0;
                        if (frame_idx_q < FRAME_LAST) begin
                            frame_idx_d = frame_idx_q + 2'd1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 6'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            DONE: begin
                state_d     = IDLE;
                frame_idx_d = 2'd0;
                hold_cnt_d  = 6'd0;
            end
            default: begin
                state_d     = IDLE;
                frame_idx_d = 2'd0;
                hold_cnt_d  = 6'd0;
            end
        endcase
    end

    // Box test and address; 15-bit wrapping arithmetic equals the 17-bit sum truncated
    always_comb begin
        x_end_s    = {1'b0, pos_x} + 11'(FRAME_W);
        y_end_s    = {1'b0, pos_y} + 11'(FRAME_H);
        inside_s   = ({1'b0, draw_x} >= {1'b0, pos_x}) && ({1'b0, draw_x} < x_end_s) &&
                     ({1'b0, draw_y} >= {1'b0, pos_y}) && ({1'b0, draw_y} < y_end_s);
        lx_s       = draw_x - pos_x;
        ly_s       = draw_y - pos_y;
        col_s      = flip ? (10'(FRAME_W - 1) - lx_s) : lx_s;
        addr_sum_s = 15'(frame_idx_q) * FRAME_SIZE + 15'(ly_s) * 15'(FRAME_W) + 15'(col_s);
        if (inside_s) begin
            rom_address_d = addr_sum_s;
            sprite_on_d   = 1'b1;
        end else begin
            rom_address_d = 15'd0;
            sprite_on_d   = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_cnt_q    <= 6'd0;
            frame_idx_q   <= 2'd0;
            rom_address_q <= 15'd0;
            sprite_on_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            frame_idx_q   <= frame_idx_d;
            rom_address_q <= rom_address_d;
            sprite_on_q   <= sprite_on_d;
        end
    end

    assign rom_address = rom_address_q;
    assign sprite_on   = sprite_on_q;
    assign frame_idx   = frame_idx_q;
    assign busy        = (state_q == PLAY);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_kof_sprite_fetch.sv
// Self-checking bench for kof_sprite_fetch: address table through a scoreboard
// plus hand-written animation, reset-abort and retrigger sequences.
module tb_kof_sprite_fetch;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        trigger = 1'b0;
    logic [9:0]  draw_x = 10'd110;
    logic [9:0]  draw_y = 10'd60;
    logic [9:0]  pos_x = 10'd100;
    logic [9:0]  pos_y = 10'd50;
    logic        flip = 1'b0;
    logic [14:0] rom_address;
    logic        sprite_on;
    logic        busy;
    logic [1:0]  frame_idx;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  dx, dy, px, py;
        logic        fl;
        logic        on;
        logic [14:0] addr;
    } vec_t;

    typedef struct {
        logic        on;
        logic [14:0] addr;
    } exp_t;

    vec_t vecs[12];
    exp_t sb_q[$];

    kof_sprite_fetch dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .trigger     (trigger),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip        (flip),
        .rom_address (rom_address),
        .sprite_on   (sprite_on),
        .busy        (busy),
        .frame_idx   (frame_idx),
        .done        (done)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one pixel, queue its expectation, compare one cycle later.
    task automatic apply_pix(input string name, input logic [9:0] dx, input logic [9:0] dy,
                             input logic [9:0] px, input logic [9:0] py, input logic fl,
                             input logic on, input logic [14:0] addr);
        exp_t e;
        @(negedge vga_clk);
        draw_x = dx; draw_y = dy; pos_x = px; pos_y = py; flip = fl;
        e.on = on; e.addr = addr;
        sb_q.push_back(e);
        @(posedge vga_clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_on"}, int'(sprite_on), int'(e.on));
            chk({name, "_addr"}, int'(rom_address), int'(e.addr));
        end
    endtask

    task automatic pulse_fs();
        @(negedge vga_clk);
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
    endtask

    task automatic start_anim();
        @(negedge vga_clk);
        trigger = 1'b1;
        @(negedge vga_clk);
        trigger = 1'b0;
    endtask

    // Pulses first..last of a 24-pulse animation, checking frame index after each.
    task automatic play_pulses(input int first, input int last);
        for (int p = first; p <= last; p++) begin
            pulse_fs();
            if (p < 24) begin
                chk($sformatf("frame_after_%0d", p), int'(frame_idx), p / 6);
                chk($sformatf("busy_after_%0d", p), int'(busy), 1);
            end else begin
                chk("done_pulse", int'(done), 1);
                chk("busy_in_done", int'(busy), 0);
            end
        end
    endtask

    initial begin
        logic done_seen;
        vecs[0]  = '{10'd110,  10'd60,   10'd100,  10'd50,   1'b0, 1'b1, 15'd650};
        vecs[1]  = '{10'd110,  10'd60,   10'd100,  10'd50,   1'b1, 1'b1, 15'd693};
        vecs[2]  = '{10'd163,  10'd145,  10'd100,  10'd50,   1'b0, 1'b1, 15'd6143};
        vecs[3]  = '{10'd164,  10'd145,  10'd100,  10'd50,   1'b0, 1'b0, 15'd0};
        vecs[4]  = '{10'd99,   10'd60,   10'd100,  10'd50,   1'b0, 1'b0, 15'd0};
        vecs[5]  = '{10'd100,  10'd50,   10'd100,  10'd50,   1'b0, 1'b1, 15'd0};
        vecs[6]  = '{10'd100,  10'd50,   10'd100,  10'd50,   1'b1, 1'b1, 15'd63};
        vecs[7]  = '{10'd100,  10'd146,  10'd100,  10'd50,   1'b0, 1'b0, 15'd0};
        vecs[8]  = '{10'd1023, 10'd1023, 10'd1000, 10'd1000, 1'b0, 1'b1, 15'd1495};
        vecs[9]  = '{10'd1010, 10'd0,    10'd1000, 10'd0,    1'b0, 1'b1, 15'd10};
        vecs[10] = '{10'd163,  10'd50,   10'd100,  10'd50,   1'b1, 1'b1, 15'd0};
        vecs[11] = '{10'd130,  10'd80,   10'd100,  10'd50,   1'b0, 1'b1, 15'd1950};

        // Reset held with an inside pixel: everything must read cleared.
        repeat (3) @(negedge vga_clk);
        chk("rst_addr", int'(rom_address), 0);
        chk("rst_on", int'(sprite_on), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_frame", int'(frame_idx), 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply_pix($sformatf("vec%0d", i), vecs[i].dx, vecs[i].dy, vecs[i].px,
                      vecs[i].py, vecs[i].fl, vecs[i].on, vecs[i].addr);
        end

        // Full animation; trigger coincides with a frame_start that must not count.
        draw_x = 10'd110; draw_y = 10'd60; pos_x = 10'd100; pos_y = 10'd50; flip = 1'b0;
        @(negedge vga_clk);
        trigger = 1'b1;
        frame_start = 1'b1;
        @(negedge vga_clk);
        trigger = 1'b0;
        frame_start = 1'b0;
        chk("play_busy", int'(busy), 1);
        chk("play_frame0", int'(frame_idx), 0);
        play_pulses(1, 12);
        apply_pix("frame2_addr", 10'd110, 10'd60, 10'd100, 10'd50, 1'b0, 1'b1, 15'd12938);
        play_pulses(13, 24);
        trigger = 1'b1;
        @(negedge vga_clk);
        trigger = 1'b0;
        chk("idle_after_done_busy", int'(busy), 0);
        chk("idle_after_done_done", int'(done), 0);
        chk("idle_after_done_frame", int'(frame_idx), 0);

        // Reset in the middle of frame 2 aborts without a done pulse.
        start_anim();
        play_pulses(1, 12);
        @(negedge vga_clk);
        reset = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        chk("abort_frame", int'(frame_idx), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_addr", int'(rom_address), 0);
        chk("abort_on", int'(sprite_on), 0);
        done_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge vga_clk);
            if (done) done_seen = 1'b1;
        end
        chk("abort_no_done", int'(done_seen), 0);

        // Trigger while playing frame 1.
        start_anim();
        play_pulses(1, 6);
        @(negedge vga_clk);
        trigger = 1'b1;
        @(negedge vga_clk);
        trigger = 1'b0;
        chk("retrig_busy", int'(busy), 1);
`ifdef KOF_SPRITE_RETRIGGER_EN
        chk("retrig_frame", int'(frame_idx), 0);
        play_pulses(1, 24);
`else
        chk("retrig_frame", int'(frame_idx), 1);
        play_pulses(7, 24);
`endif
        @(negedge vga_clk);
        chk("retrig_end_busy", int'(busy), 0);
        chk("retrig_end_done", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kof_sprite_fetch.md
KOF_SPRITE_FETCH -- requirements
Module: kof_sprite_fetch

Interface
REQ-001 Parameter FRAME_W, default 64, sprite frame width in pixels.
REQ-002 Parameter FRAME_H, default 96, sprite frame height in pixels.
REQ-003 Parameter NUM_FRAMES, default 4, animation frames stored back-to-back in the sprite ROM.
REQ-004 Parameter FRAME_HOLD, default 6, video frames each animation frame is held; legal range 1..63.
REQ-005 Port vga_clk, input, 1, sole clock. All logic is on the rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high reset.
REQ-007 Port frame_start, input, 1, one-cycle pulse per video frame (vertical sync).
REQ-008 Port trigger, input, 1, one-cycle request to start the animation.
REQ-009 Port draw_x, input, 10, current pixel column.
REQ-010 Port draw_y, input, 10, current pixel row.
REQ-011 Port pos_x, input, 10, sprite top-left column.
REQ-012 Port pos_y, input, 10, sprite top-left row.
REQ-013 Port flip, input, 1, horizontal mirror enable.
REQ-014 Port rom_address, output, 15, sprite ROM address (registered).
REQ-015 Port sprite_on, output, 1, current pixel lies inside the sprite box (registered, aligned with rom_address).
REQ-016 Port busy, output, 1, animation in progress.
REQ-017 Port frame_idx, output, 2, current animation frame.
REQ-018 Port done, output, 1, one-cycle pulse at animation end.

Function
REQ-019 The FSM SHALL have three states: IDLE, PLAY and DONE.
  - IDLE: frame_idx=0 and busy=0.
  - PLAY: busy=1.
  - DONE: done=1 and busy=0.
REQ-020 In IDLE, trigger=1 SHALL move the FSM to PLAY on the next edge with frame_idx=0 and hold_cnt=0.
  - A frame_start in the same cycle is not counted.
REQ-021 In PLAY, each frame_start SHALL increment hold_cnt.
  - When hold_cnt==FRAME_HOLD-1 and frame_start=1, hold_cnt is cleared.
  - If frame_idx<NUM_FRAMES-1, frame_idx increments.
  - Otherwise the FSM goes to DONE.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-023 In DONE, a trigger SHALL be ignored.
REQ-024 inside SHALL be true when draw_x>=pos_x, draw_x<pos_x+FRAME_W, draw_y>=pos_y and draw_y<pos_y+FRAME_H.
  - All compares use 11-bit unsigned arithmetic, so no wrap occurs near column or row 1023.
REQ-025 The local column and row SHALL be computed as follows.
  - lx=draw_x-pos_x and ly=draw_y-pos_y.
  - col=flip ? FRAME_W-1-lx : lx.
REQ-026 When inside, the next rom_address SHALL be frame_idx*FRAME_W*FRAME_H + ly*FRAME_W + col.
  - The sum is computed at 17 bits and truncated to 15 bits.
  - Parameters SHALL satisfy FRAME_W*FRAME_H*NUM_FRAMES<=32768; the default is 24576.
REQ-027 When not inside, the next rom_address SHALL be 0 and the next sprite_on SHALL be 0.
REQ-028 rom_address and sprite_on SHALL have exactly one cycle of latency from draw_x/draw_y.
  - They are updated every cycle regardless of FSM state.
  - In IDLE they address frame 0 (standing pose).
REQ-029 The frame_idx value used for addressing SHALL be the registered value at the sampling edge.
  - A mid-line frame change is permitted; the driver restricts frame_start to blanking.

Reset
REQ-030 When reset=1 at an edge, the following SHALL be cleared at that edge, overriding all other inputs:
  - FSM goes to IDLE.
  - hold_cnt=0 and frame_idx=0.
  - busy=0 and done=0.
  - rom_address=0 and sprite_on=0.
REQ-031 A reset during PLAY SHALL abort the animation with no done pulse.

Configuration
REQ-032 With macro KOF_SPRITE_RETRIGGER_EN defined, trigger=1 in PLAY SHALL restart the animation on the next edge.
  - frame_idx=0 and hold_cnt=0; busy stays 1.
  - If the restart coincides with a frame_start that would have advanced the frame, the restart wins.
REQ-033 With KOF_SPRITE_RETRIGGER_EN undefined, trigger in PLAY SHALL be ignored.

Verification
REQ-034 Address mapping: pos=(100,50), flip=0, IDLE, draw=(110,60) -> next cycle sprite_on=1, rom_address=650.
  - Same case with flip=1 -> rom_address=693.
REQ-035 Box edges: pos=(100,50), draw=(163,145) -> sprite_on=1, rom_address=6143.
  - draw=(164,145) or (99,60) -> sprite_on=0, rom_address=0.
REQ-036 Full animation: trigger, then 24 frame_start pulses.
  - frame_idx steps 0,1,2,3 after pulses 6, 12 and 18.
  - busy=1 throughout.
  - After pulse 24: DONE for one cycle with done=1, then IDLE with busy=0.
REQ-037 Frame 2 addressing: in PLAY at frame_idx=2 with draw=(110,60) -> rom_address=12938.
REQ-038 Reset mid-animation: at frame_idx=2, assert reset for one cycle.
  - Next cycle: frame_idx=0, busy=0, done never pulses, rom_address=0.
REQ-039 Retrigger: trigger at frame_idx=1.
  - With KOF_SPRITE_RETRIGGER_EN: frame_idx=0 on the next cycle and busy stays 1.
  - Without it: frame_idx stays 1 and the sequence completes after 24 total pulses.
